// File: rtl/hdmi_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_pkg
//   Shared definitions for the HDMI frame gate:
//   - gate_state_t : frame gate state encoding (IDLE=0, ARM=1, PASS=2, DROP=3)
//   - DEF_H_ACT / DEF_V_ACT / DEF_CW : default active geometry and counter width
//   - rgb888_to_565 : truncating colour-depth reduction {R[7:3],G[7:2],B[7:3]}
// -----------------------------------------------------------------------------
package hdmi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PASS = 2'd2,
        ST_DROP = 2'd3
    } gate_state_t;

    localparam int DEF_H_ACT = 1280;
    localparam int DEF_V_ACT = 720;
    localparam int DEF_CW    = 12;

    // Keep the top bits of each channel; no rounding.
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/hdmi_geom_meter.sv
// -----------------------------------------------------------------------------
// hdmi_geom_meter
//   Measures frame geometry on the stage-1 video signals.
//   Ports:
//     clk, rst_n          : pixel clock, synchronous active-low reset
//     de_s1, vs_s1        : stage-1 data enable / vsync
//     vs_rise             : vsync rising edge (combinational, stage-1 timing)
//     width_bad           : line just closed with a length other than H_ACT
//     height_bad          : frame just closed with a height other than V_ACT
//     meas_width          : x count latched at the last de falling edge
//     meas_height         : line count latched at the last vsync rising edge
// -----------------------------------------------------------------------------
module hdmi_geom_meter
    import hdmi_pkg::*;
#(
    parameter int H_ACT = DEF_H_ACT,
    parameter int V_ACT = DEF_V_ACT,
    parameter int CW    = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          de_s1,
    input  logic          vs_s1,
    output logic          vs_rise,
    output logic          width_bad,
    output logic          height_bad,
    output logic [CW-1:0] meas_width,
    output logic [CW-1:0] meas_height
);

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] H_EXP    = CW'(H_ACT);
    localparam logic [CW-1:0] V_EXP    = CW'(V_ACT);

    logic          de_p_r;
    logic          vs_p_r;
    logic [CW-1:0] x_r;
    logic [CW-1:0] y_r;
    logic          de_fall_s;
    logic [CW-1:0] y_eff_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    // Edge detection and geometry compare pulses.
    always_comb begin
        de_fall_s  = ~de_s1 & de_p_r;
        vs_rise    = vs_s1 & ~vs_p_r;
        // A line closing on the vsync edge itself still counts toward this frame.
        y_eff_s    = de_fall_s ? sat_inc(y_r) : y_r;
        width_bad  = de_fall_s & (x_r != H_EXP);
        height_bad = vs_rise & (y_eff_s != V_EXP);
    end

    // Previous-value registers, x/y counters and measured-size latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_p_r      <= 1'b0;
            vs_p_r      <= 1'b0;
            x_r         <= CNT_ZERO;
            y_r         <= CNT_ZERO;
            meas_width  <= CNT_ZERO;
            meas_height <= CNT_ZERO;
        end else begin
            de_p_r <= de_s1;
            vs_p_r <= vs_s1;

            if (de_s1) begin
                x_r <= sat_inc(x_r);
            end else if (de_fall_s) begin
                x_r <= CNT_ZERO;
            end else begin
                x_r <= x_r;
            end

            if (vs_rise) begin
                y_r <= CNT_ZERO;
            end else if (de_fall_s) begin
                y_r <= sat_inc(y_r);
            end else begin
                y_r <= y_r;
            end

            if (de_fall_s) begin
                meas_width <= x_r;
            end else begin
                meas_width <= meas_width;
            end

            if (vs_rise) begin
                meas_height <= y_eff_s;
            end else begin
                meas_height <= meas_height;
            end
        end
    end

endmodule

// File: rtl/hdmi_frame_gate.sv
// -----------------------------------------------------------------------------
// hdmi_frame_gate
//   Converts RGB888 to RGB565 and forwards only whole, well-formed frames,
//   starting at a vsync edge after capture is enabled. Fixed 2-cycle latency.
//   Ports:
//     hdmi_clk, rst_n        : pixel clock, synchronous active-low reset
//     cap_en                 : capture enable level (hdmi_clk domain)
//     err_clr                : pulse clearing the sticky error flags
//     vin_de/hs/vs, vin_rgb  : receiver video {R,G,B}
//     hdmi_vld, hdmi_565     : gated pixel valid / RGB565 (0 when not valid)
//     hdmi_hsync/vsync       : delayed syncs, never gated
//     frame_cnt              : complete, error-free frames forwarded (wraps)
//     meas_width/height      : last measured line length / frame height
//     err_width/err_height   : sticky geometry error flags
// -----------------------------------------------------------------------------
module hdmi_frame_gate
    import hdmi_pkg::*;
#(
    parameter int H_ACT = DEF_H_ACT,
    parameter int V_ACT = DEF_V_ACT,
    parameter int CW    = DEF_CW
) (
    input  logic          hdmi_clk,
    input  logic          rst_n,
    input  logic          cap_en,
    input  logic          err_clr,
    input  logic          vin_de,
    input  logic          vin_hs,
    input  logic          vin_vs,
    input  logic [23:0]   vin_rgb,
    output logic          hdmi_vld,
    output logic          hdmi_hsync,
    output logic          hdmi_vsync,
    output logic [15:0]   hdmi_565,
    output logic [15:0]   frame_cnt,
    output logic [CW-1:0] meas_width,
    output logic [CW-1:0] meas_height,
    output logic          err_width,
    output logic          err_height
);

    gate_state_t state_r;
    gate_state_t next_state_s;

    logic        de_s1_r;
    logic        hs_s1_r;
    logic        vs_s1_r;
    logic [23:0] rgb_s1_r;

    logic        vs_rise_s;
    logic        width_bad_s;
    logic        height_bad_s;

    logic        set_werr_s;
    logic        set_herr_s;
    logic        frame_done_s;
    logic        pass_s;
    logic        fwd_s;

    // Stage 1: register the receiver inputs.
    always_ff @(posedge hdmi_clk) begin
        if (!rst_n) begin
            de_s1_r  <= 1'b0;
            hs_s1_r  <= 1'b0;
            vs_s1_r  <= 1'b0;
            rgb_s1_r <= 24'h000000;
        end else begin
            de_s1_r  <= vin_de;
            hs_s1_r  <= vin_hs;
            vs_s1_r  <= vin_vs;
            rgb_s1_r <= vin_rgb;
        end
    end

    hdmi_geom_meter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .CW    (CW)
    ) u_meter (
        .clk         (hdmi_clk),
        .rst_n       (rst_n),
        .de_s1       (de_s1_r),
        .vs_s1       (vs_s1_r),
        .vs_rise     (vs_rise_s),
        .width_bad   (width_bad_s),
        .height_bad  (height_bad_s),
        .meas_width  (meas_width),
        .meas_height (meas_height)
    );

    // Gate state register.
    always_ff @(posedge hdmi_clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic, error/frame pulses and pixel gating.
    always_comb begin
        next_state_s = state_r;
        set_werr_s   = 1'b0;
        set_herr_s   = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cap_en) begin
                    next_state_s = ST_ARM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!cap_en) begin
                    next_state_s = ST_IDLE;
                end else if (vs_rise_s) begin
                    next_state_s = ST_PASS;
                end else begin
                    next_state_s = ST_ARM;
                end
            end
            ST_PASS: begin
                set_werr_s = width_bad_s;
                if (vs_rise_s) begin
                    // Frame boundary: account for the frame, then decide the next one.
                    set_herr_s   = height_bad_s;
                    frame_done_s = ~height_bad_s & ~width_bad_s;
                    if (cap_en) begin
                        next_state_s = ST_PASS;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else if (width_bad_s) begin
                    next_state_s = ST_DROP;
                end else begin
                    next_state_s = ST_PASS;
                end
            end
            ST_DROP: begin
                if (vs_rise_s) begin
                    if (cap_en) begin
                        next_state_s = ST_PASS;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_DROP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        // Looking at next state lets the first pixel after the arming vsync through.
        pass_s = (state_r == ST_PASS) | (next_state_s == ST_PASS);
        fwd_s  = de_s1_r & pass_s;
    end

    // Stage 2: registered outputs, frame counter and sticky flags.
    always_ff @(posedge hdmi_clk) begin
        if (!rst_n) begin
            hdmi_vld   <= 1'b0;
            hdmi_565   <= 16'h0000;
            hdmi_hsync <= 1'b0;
            hdmi_vsync <= 1'b0;
            frame_cnt  <= 16'h0000;
            err_width  <= 1'b0;
            err_height <= 1'b0;
        end else begin
            hdmi_vld   <= fwd_s;
            hdmi_565   <= fwd_s ? rgb888_to_565(rgb_s1_r) : 16'h0000;
            hdmi_hsync <= hs_s1_r;
            hdmi_vsync <= vs_s1_r;
            if (frame_done_s) begin
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
            // A new error wins over a coincident clear.
            err_width  <= set_werr_s | (err_width  & ~err_clr);
            err_height <= set_herr_s | (err_height & ~err_clr);
        end
    end

endmodule

// File: tb/tb_hdmi_frame_gate.sv
// -----------------------------------------------------------------------------
// tb_hdmi_frame_gate
//   Scoreboard bench: the driver pushes the expected output of each driven
//   cycle (due two cycles later), a monitor pops and compares. Frame-level
//   reference model tracks capture mode, frame count, flags and sizes.
// -----------------------------------------------------------------------------
module tb_hdmi_frame_gate;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int CW = 12;

    logic          hdmi_clk = 1'b0;
    logic          rst_n    = 1'b0;
    logic          cap_en   = 1'b0;
    logic          err_clr  = 1'b0;
    logic          vin_de   = 1'b0;
    logic          vin_hs   = 1'b0;
    logic          vin_vs   = 1'b0;
    logic [23:0]   vin_rgb  = 24'h000000;
    logic          hdmi_vld;
    logic          hdmi_hsync;
    logic          hdmi_vsync;
    logic [15:0]   hdmi_565;
    logic [15:0]   frame_cnt;
    logic [CW-1:0] meas_width;
    logic [CW-1:0] meas_height;
    logic          err_width;
    logic          err_height;

    hdmi_frame_gate #(.H_ACT(H), .V_ACT(V), .CW(CW)) dut (
        .hdmi_clk    (hdmi_clk),
        .rst_n       (rst_n),
        .cap_en      (cap_en),
        .err_clr     (err_clr),
        .vin_de      (vin_de),
        .vin_hs      (vin_hs),
        .vin_vs      (vin_vs),
        .vin_rgb     (vin_rgb),
        .hdmi_vld    (hdmi_vld),
        .hdmi_hsync  (hdmi_hsync),
        .hdmi_vsync  (hdmi_vsync),
        .hdmi_565    (hdmi_565),
        .frame_cnt   (frame_cnt),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .err_width   (err_width),
        .err_height  (err_height)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    typedef struct {
        int          due;
        logic        vld;
        logic [15:0] px;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          cyc      = 0;
    int          tests    = 0;
    int          fails    = 0;
    int          vld_seen = 0;
    logic [15:0] last_px  = 16'h0000;

    // Reference model state (frame level). mode: 0 off, 1 armed, 2 capturing.
    int mode  = 0;
    int bad   = 0;   // a wrong-length line occurred in the current captured frame
    int lines = 0;
    int fc    = 0;
    int ew    = 0;
    int eh    = 0;
    int mw    = 0;
    int mh    = 0;
    int cap   = 0;

    always @(posedge hdmi_clk) cyc <= cyc + 1;

    // Monitor: compare every due output cycle against the scoreboard.
    always @(negedge hdmi_clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e_mon = sb.pop_front();
            tests++;
            if (e_mon.due != cyc || hdmi_vld !== e_mon.vld || hdmi_565 !== e_mon.px ||
                hdmi_hsync !== e_mon.hs || hdmi_vsync !== e_mon.vs) begin
                fails++;
                $display("FAIL pixel cyc=%0d: got vld=%b px=%h hs=%b vs=%b, want due=%0d vld=%b px=%h hs=%b vs=%b",
                         cyc, hdmi_vld, hdmi_565, hdmi_hsync, hdmi_vsync,
                         e_mon.due, e_mon.vld, e_mon.px, e_mon.hs, e_mon.vs);
            end
        end
        if (hdmi_vld === 1'b1) begin
            vld_seen++;
            last_px = hdmi_565;
        end
    end

    function automatic logic [15:0] to565(input logic [23:0] c);
        int r, g, b;
        r = int'(c[23:16]);
        g = int'(c[15:8]);
        b = int'(c[7:0]);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [23:0] rgb, input logic fwd);
        exp_t e;
        vin_de  = de;
        vin_hs  = hs;
        vin_vs  = vs;
        vin_rgb = rgb;
        e.due = cyc + 2;
        e.vld = de & fwd;
        e.px  = (de & fwd) ? to565(rgb) : 16'h0000;
        e.hs  = hs;
        e.vs  = vs;
        sb.push_back(e);
        @(posedge hdmi_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 24'h000000, 1'b0);
    endtask

    task automatic set_cap(input int v);
        cap    = v;
        cap_en = (v != 0);
        if (v != 0 && mode == 0) mode = 1;
        else if (v == 0 && mode == 1) mode = 0;
        idle(3);
    endtask

    // Vsync pulse: closes the previous frame in the model and opens a new one.
    task automatic vs_pulse();
        mh = lines;
        if (mode == 2) begin
            if (bad == 0) begin
                if (lines == V) fc = (fc + 1) % 65536;
                else eh = 1;
            end
            mode = (cap != 0) ? 2 : 0;
        end else if (mode == 1) begin
            mode = 2;
        end
        lines = 0;
        bad   = 0;
        repeat (3) drive(1'b0, 1'b0, 1'b1, 24'h000000, 1'b0);
        idle(4);
    endtask

    task automatic line(input int len, input logic fixed, input logic [23:0] px);
        logic        fwd;
        logic [23:0] c;
        fwd = (mode == 2) && (bad == 0);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 24'h000000, 1'b0);
        idle($urandom_range(1, 3));
        for (int i = 0; i < len; i++) begin
            c = fixed ? px : 24'($urandom);
            drive(1'b1, 1'b0, 1'b0, c, fwd);
        end
        lines++;
        mw = len;
        if (mode == 2 && bad == 0 && len != H) begin
            bad = 1;
            ew  = 1;
        end
        idle(3);
    endtask

    task automatic check_regs(input string tag);
        @(negedge hdmi_clk);
        chk({tag, ".frame_cnt"},   int'(frame_cnt),   fc);
        chk({tag, ".err_width"},   int'(err_width),   ew);
        chk({tag, ".err_height"},  int'(err_height),  eh);
        chk({tag, ".meas_width"},  int'(meas_width),  mw);
        chk({tag, ".meas_height"}, int'(meas_height), mh);
    endtask

    task automatic check_zero(input string tag);
        @(negedge hdmi_clk);
        chk({tag, ".vld"},   int'(hdmi_vld),   0);
        chk({tag, ".hsync"}, int'(hdmi_hsync), 0);
        chk({tag, ".vsync"}, int'(hdmi_vsync), 0);
        chk({tag, ".565"},   int'(hdmi_565),   0);
    endtask

    initial begin
        int nl, len;
        // Reset state.
        repeat (3) @(posedge hdmi_clk);
        #1;
        rst_n = 1'b1;
        check_zero("reset");
        check_regs("reset");
        idle(4);

        // Nominal: three well-formed frames, fixed colour.
        set_cap(1);
        vld_seen = 0;
        for (int f = 0; f < 3; f++) begin
            vs_pulse();
            for (int l = 0; l < V; l++) line(H, 1'b1, 24'hFF8008);
        end
        vs_pulse();
        check_regs("nominal");
        chk("nominal.vld_count", vld_seen, 3 * H * V);
        chk("nominal.last_565", int'(last_px), int'(16'hFC01));

        // Disable at line 1: frame still forwarded in full.
        vld_seen = 0;
        line(H, 1'b0, 24'h0);
        set_cap(0);
        for (int l = 1; l < V; l++) line(H, 1'b0, 24'h0);
        vs_pulse();
        check_regs("disable");
        chk("disable.vld_count", vld_seen, H * V);

        // Enable mid-frame: nothing from this frame.
        vld_seen = 0;
        line(H, 1'b0, 24'h0);
        line(H, 1'b0, 24'h0);
        set_cap(1);
        line(H, 1'b0, 24'h0);
        line(H, 1'b0, 24'h0);
        vs_pulse();
        chk("enable_mid.vld_count", vld_seen, 0);

        // Short line 2: lines 1-2 forwarded, 3-4 gated.
        vld_seen = 0;
        line(H, 1'b0, 24'h0);
        line(H - 1, 1'b0, 24'h0);
        check_regs("short_line");
        line(H, 1'b0, 24'h0);
        line(H, 1'b0, 24'h0);
        vs_pulse();
        chk("short_line.vld_count", vld_seen, 2 * H - 1);
        for (int l = 0; l < V; l++) line(H, 1'b0, 24'h0);
        vs_pulse();
        check_regs("after_short_line");

        // Short frame of 3 lines, then clear the flags.
        for (int l = 0; l < V - 1; l++) line(H, 1'b0, 24'h0);
        vs_pulse();
        check_regs("short_frame");
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        ew = 0;
        eh = 0;
        check_regs("err_clr");

        // One more frame with cap_en dropped, then reset mid-line while idle.
        line(H, 1'b0, 24'h0);
        set_cap(0);
        for (int l = 1; l < V; l++) line(H, 1'b0, 24'h0);
        vs_pulse();
        check_regs("before_reset");
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
        rst_n = 1'b0;
        sb.delete();
        @(posedge hdmi_clk);
        #1;
        rst_n  = 1'b1;
        vin_de = 1'b0;
        mode = 0; bad = 0; lines = 0; fc = 0; ew = 0; eh = 0; mw = 0; mh = 0;
        check_zero("mid_reset");
        check_regs("mid_reset");
        idle(4);

        // Randomised frames.
        set_cap(1);
        for (int f = 0; f < 8; f++) begin
            vs_pulse();
            nl = (($urandom_range(0, 3) == 0) ? (V - 1 + 2 * $urandom_range(0, 1)) : V);
            for (int l = 0; l < nl; l++) begin
                len = ($urandom_range(0, 5) == 0) ? (H - 1 + 2 * $urandom_range(0, 1)) : H;
                line(len, 1'b0, 24'h0);
            end
        end
        vs_pulse();
        check_regs("random");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge hdmi_clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
